// File: rtl/instr_encoder_loader.sv
// Packs assembled instruction fields into 32-bit words and writes them
// into instruction memory at consecutive addresses from 0.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [3:0]        in_dest,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, DONE, ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t      state;
  logic        last_q;
  logic        legal;
  logic        is_reg;
  logic        is_imm;
  logic        is_movb;
  logic [31:0] enc;

  assign legal   = (in_opcode <= 5'd21);
  assign is_reg  = in_opcode inside {[5'd2:5'd7], [5'd14:5'd17], 5'd21};
  assign is_imm  = in_opcode inside {5'd1, [5'd8:5'd12], [5'd18:5'd20]};
  assign is_movb = (in_opcode == 5'd13);

  // NOP and illegal opcodes leave everything below the opcode at zero
  always_comb begin
    enc = '0;
    enc[31:27] = in_opcode;
    unique case (1'b1)
      is_reg: begin
        enc[26:23] = in_dest;
        enc[22:19] = in_a;
        enc[18:15] = in_b;
      end
      is_imm: begin
        enc[26:23] = in_dest;
        enc[22:19] = in_a;
        enc[18:3]  = in_imm;
      end
      is_movb: begin
        enc[26:23] = in_dest;
        enc[22:19] = in_b;
        enc[18:15] = in_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LOAD;
            imem_addr  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (legal) begin
              imem_we    <= 1'b1;
              imem_wdata <= enc;
              last_q     <= in_last;
              state      <= WRITE;
            end else begin
              error    <= 1'b1;
              err_code <= 2'b01;
              busy     <= 1'b0;
              state    <= ERR;
            end
          end
        end
        WRITE: begin
          imem_we    <= 1'b0;
          imem_addr  <= imem_addr + 1'b1;
          word_count <= word_count + 1'b1;
          if (last_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (imem_addr == LAST_ADDR) begin
            error    <= 1'b1;
            err_code <= 2'b10;
            busy     <= 1'b0;
            state    <= ERR;
          end else begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-depth instance
// and a DEPTH=4 instance share the field inputs but have separate starts.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [3:0]  in_dest;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [15:0] in_imm;
  logic        in_last;

  logic        a_ready, a_we, a_busy, a_done, a_error;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [1:0]  a_ec;
  logic [8:0]  a_wc;

  logic        b_ready, b_we, b_busy, b_done, b_error;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_ec;
  logic [8:0]  b_wc;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_a(in_a),
    .in_b(in_b), .in_imm(in_imm), .in_last(in_last),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .error(a_error),
    .err_code(a_ec), .word_count(a_wc)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_a(in_a),
    .in_b(in_b), .in_imm(in_imm), .in_last(in_last),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .error(b_error),
    .err_code(b_ec), .word_count(b_wc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t ea;
  wr_t eb;
  int  nxt_a = 0;
  int  nxt_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op,
      input logic [3:0] d, input logic [3:0] ra, input logic [3:0] rb,
      input logic [15:0] imm);
    logic [31:0] w;
    w = {op, 27'b0};
    case (op)
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd14, 5'd15, 5'd16, 5'd17, 5'd21:
        w = w | {5'b0, d, ra, rb, 15'b0};
      5'd1, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
      5'd18, 5'd19, 5'd20:
        w = w | {5'b0, d, ra, imm, 3'b0};
      5'd13:
        w = w | {5'b0, d, rb, ra, 15'b0};
      default: ;
    endcase
    return w;
  endfunction

  // Scoreboard: every write strobe pops the oldest expected write
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_write", 32'(a_addr), 32'hFFFF_FFFF);
      end else begin
        ea = qa.pop_front();
        chk("a_addr", 32'(a_addr), 32'(ea.addr));
        chk("a_wdata", a_wdata, ea.data);
      end
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_write", 32'(b_addr), 32'hFFFF_FFFF);
      end else begin
        eb = qb.pop_front();
        chk("b_addr", 32'(b_addr), 32'(eb.addr));
        chk("b_wdata", b_wdata, eb.data);
      end
    end
  end

  task automatic pulse_start(input bit to_b);
    @(negedge clk);
    if (to_b) begin start_b = 1'b1; nxt_b = 0; end
    else begin start_a = 1'b1; nxt_a = 0; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit to_b, input logic [4:0] op,
      input logic [3:0] d, input logic [3:0] ra, input logic [3:0] rb,
      input logic [15:0] imm, input bit last, input bit push,
      input logic [31:0] expw, input bit hold);
    bit ok;
    logic rdy;
    ok = 1'b0;
    @(negedge clk);
    in_opcode = op;
    in_dest   = d;
    in_a      = ra;
    in_b      = rb;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = to_b ? b_ready : a_ready;
      if (rdy === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) begin
          if (to_b) begin
            qb.push_back(wr_t'{addr: 8'(nxt_b), data: expw});
            nxt_b++;
          end else begin
            qa.push_back(wr_t'{addr: 8'(nxt_a), data: expw});
            nxt_a++;
          end
        end
        #1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    if (!hold || !ok) in_valid = 1'b0;
  endtask

  task automatic wait_end(input bit to_b);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = to_b ? (b_done | b_error) : (a_done | a_error);
    end
    if (!hit) chk("end_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    logic [4:0]  op;
    logic [3:0]  d, ra, rb;
    logic [15:0] imm;

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    in_valid = 1'b0;
    in_opcode = '0;
    in_dest = '0;
    in_a = '0;
    in_b = '0;
    in_imm = '0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_flags", 32'({a_busy, a_done, a_error, a_ec}), 32'd0);
    chk("rst_wc", 32'(a_wc), 32'd0);
    chk("rst_addr_data", 32'(a_addr) | a_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(a_ready), 32'd0);

    // ADD single instruction
    pulse_start(1'b0);
    chk("load_ready", 32'(a_ready), 32'd1);
    chk("load_busy", 32'(a_busy), 32'd1);
    send(1'b0, 5'd2, 4'd3, 4'd1, 4'd2, 16'h0, 1'b1, 1'b1, 32'h1189_0000, 1'b0);
    wait_end(1'b0);
    chk("add_done", 32'(a_done), 32'd1);
    chk("add_wc", 32'(a_wc), 32'd1);
    chk("add_busy", 32'(a_busy), 32'd0);

    // ADI then MOVB
    pulse_start(1'b0);
    send(1'b0, 5'd8, 4'd5, 4'd5, 4'd9, 16'h00FF, 1'b0, 1'b1, 32'h42A8_07F8, 1'b0);
    send(1'b0, 5'd13, 4'd2, 4'd7, 4'd4, 16'hBEEF, 1'b1, 1'b1, 32'h6923_8000, 1'b0);
    wait_end(1'b0);
    chk("movb_wc", 32'(a_wc), 32'd2);

    // JMP then NOP, unused fields nonzero
    pulse_start(1'b0);
    send(1'b0, 5'd20, 4'd0, 4'd0, 4'd6, 16'h0010, 1'b0, 1'b1, 32'hA000_0080, 1'b0);
    send(1'b0, 5'd0, 4'd9, 4'd8, 4'd7, 16'h1234, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    wait_end(1'b0);
    chk("nop_done", 32'(a_done), 32'd1);

    // Illegal opcode after one good word, then restart
    pulse_start(1'b0);
    send(1'b0, 5'd2, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0, 1'b1, 32'h1189_0000, 1'b0);
    send(1'b0, 5'd25, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_end(1'b0);
    chk("ill_error", 32'(a_error), 32'd1);
    chk("ill_code", 32'(a_ec), 32'd1);
    chk("ill_wc", 32'(a_wc), 32'd1);
    chk("ill_done", 32'(a_done), 32'd0);
    pulse_start(1'b0);
    chk("restart_clear", 32'({a_error, a_ec, a_done}), 32'd0);
    chk("restart_wc", 32'(a_wc), 32'd0);
    send(1'b0, 5'd3, 4'd4, 4'd5, 4'd6, 16'h0, 1'b1, 1'b1,
         model(5'd3, 4'd4, 4'd5, 4'd6, 16'h0), 1'b0);
    wait_end(1'b0);

    // Random legal program of six instructions
    pulse_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      op  = 5'($urandom_range(0, 21));
      d   = 4'($urandom);
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      imm = 16'($urandom);
      send(1'b0, op, d, ra, rb, imm, i == 5, 1'b1,
           model(op, d, ra, rb, imm), 1'b0);
    end
    wait_end(1'b0);
    chk("rand_wc", 32'(a_wc), 32'd6);
    chk("rand_done", 32'(a_done), 32'd1);

    // Overflow on the DEPTH=4 instance
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 5'd9, 4'(i), 4'd1, 4'd0, 16'(i * 3), 1'b0, 1'b1,
           model(5'd9, 4'(i), 4'd1, 4'd0, 16'(i * 3)), 1'b0);
    end
    @(negedge clk);
    in_opcode = 5'd2;
    in_last = 1'b0;
    in_valid = 1'b1;
    wait_end(1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_ready", 32'(b_ready), 32'd0);
    chk("ovf_error", 32'(b_error), 32'd1);
    chk("ovf_code", 32'(b_ec), 32'd2);
    chk("ovf_wc", 32'(b_wc), 32'd4);
    in_valid = 1'b0;

    // Reset while the write strobe is up
    pulse_start(1'b0);
    send(1'b0, 5'd4, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_we", 32'(a_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_now", 32'(a_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", 32'(a_ready), 32'd0);
    chk("post_rst_state", 32'({a_busy, a_done, a_error}), 32'd0);
    chk("post_rst_wc", 32'(a_wc), 32'd0);
    in_valid = 1'b0;
    pulse_start(1'b0);
    send(1'b0, 5'd1, 4'd7, 4'd2, 4'd0, 16'hA5A5, 1'b1, 1'b1,
         model(5'd1, 4'd7, 4'd2, 4'd0, 16'hA5A5), 1'b0);
    wait_end(1'b0);
    chk("after_rst_wc", 32'(a_wc), 32'd1);

    repeat (2) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
